// File: rtl/puf_pkg.sv
// Shared types and constants for the arbiter-PUF CRP controller.
package puf_pkg;

    // Controller phases
    typedef enum logic [2:0] {
        StIdle,
        StApply,
        StRace,
        StSample,
        StClear,
        StPresent
    } puf_state_e;

    // Widest LFSR the tap table covers
    localparam int unsigned MAX_N = 128;

    // Race-count width; holds up to 15 votes
    localparam int unsigned ONES_W = 4;

    // Phase hold counter width
    localparam int unsigned PHASE_W = 8;

    // Maximal-length Fibonacci tap masks, keyed by LFSR width
    function automatic logic [MAX_N-1:0] lfsr_taps(input int unsigned n);
        logic [MAX_N-1:0] t;
        t = '0;
        case (n)
            8: begin
                t[7] = 1'b1; t[5] = 1'b1; t[4] = 1'b1; t[3] = 1'b1;
            end
            16: begin
                t[15] = 1'b1; t[14] = 1'b1; t[12] = 1'b1; t[3] = 1'b1;
            end
            32: begin
                t[31] = 1'b1; t[21] = 1'b1; t[1] = 1'b1; t[0] = 1'b1;
            end
            64: begin
                t[63] = 1'b1; t[62] = 1'b1; t[60] = 1'b1; t[59] = 1'b1;
            end
            default: begin
                // x^128 + x^126 + x^101 + x^99 + 1
                t[127] = 1'b1; t[125] = 1'b1; t[100] = 1'b1; t[98] = 1'b1;
            end
        endcase
        return t;
    endfunction

endpackage

// File: rtl/puf_lfsr.sv
// Challenge generator: N-bit Fibonacci LFSR, shifts left, feedback into the LSB.
module puf_lfsr
    import puf_pkg::*;
#(
    parameter int unsigned N = 128
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [N-1:0] seed,
    input  logic         step,
    output logic [N-1:0] state
);

    localparam logic [MAX_N-1:0] TAPS     = lfsr_taps(N);
    localparam logic [N-1:0]     TAP_MASK = TAPS[N-1:0];

    logic fb;
    assign fb = ^(state & TAP_MASK);

    // Load the seed (zero seed mapped to all-ones so the lock-up state is never entered) or step
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= '0;
        end else if (load) begin
            state <= (seed == '0) ? '1 : seed;
        end else if (step) begin
            state <= {state[N-2:0], fb};
        end
    end

endmodule

// File: rtl/puf_crp_controller.sv
// Drives an arbiter PUF: applies LFSR challenges, launches races, majority-votes the
// synchronised latch output and streams challenge/response pairs on a valid/ready port.
module puf_crp_controller
    import puf_pkg::*;
#(
    parameter int unsigned N      = 128,
    parameter int unsigned SETTLE = 8,
    parameter int unsigned VOTES  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [N-1:0]      seed,
    input  logic [15:0]       n_crp,
    output logic [N-1:0]      puf_sel,
    output logic              puf_in,
    output logic              puf_reset,
    input  logic              puf_out,
    output logic              crp_valid,
    input  logic              crp_ready,
    output logic [N-1:0]      crp_challenge,
    output logic              crp_response,
    output logic [ONES_W-1:0] crp_ones,
    output logic              busy,
    output logic              done
);

    localparam logic [PHASE_W-1:0] HOLD    = PHASE_W'(SETTLE - 1);
    localparam logic [PHASE_W-1:0] SYNC_HD = PHASE_W'(1);
    localparam logic [ONES_W-1:0]  NVOTES  = ONES_W'(VOTES);
    localparam logic [ONES_W-1:0]  HALF    = ONES_W'(VOTES / 2);

    puf_state_e         state;
    logic [PHASE_W-1:0] phase;
    logic [ONES_W-1:0]  ones;
    logic [ONES_W-1:0]  vote;
    logic [15:0]        remaining;
    logic               sync1;
    logic               sync2;
    logic [N-1:0]       lfsr_state;
    logic               lfsr_load;
    logic               lfsr_step;

    assign lfsr_load = (state == StIdle) && start;
    assign lfsr_step = (state == StPresent) && crp_valid && crp_ready;

    puf_lfsr #(
        .N(N)
    ) u_lfsr (
        .clk  (clk),
        .reset(reset),
        .load (lfsr_load),
        .seed (seed),
        .step (lfsr_step),
        .state(lfsr_state)
    );

    // Two-flop synchroniser for the asynchronous PUF latch output
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= puf_out;
            sync2 <= sync1;
        end
    end

    // Phase sequencer; every output is registered here
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= StIdle;
            phase         <= '0;
            ones          <= '0;
            vote          <= '0;
            remaining     <= '0;
            puf_sel       <= '0;
            puf_in        <= 1'b0;
            puf_reset     <= 1'b1;
            crp_valid     <= 1'b0;
            crp_challenge <= '0;
            crp_response  <= 1'b0;
            crp_ones      <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (start) begin
                        remaining <= n_crp;
                        ones      <= '0;
                        vote      <= '0;
                        if (n_crp == 16'd0) begin
                            done <= 1'b1;
                        end else begin
                            state     <= StApply;
                            phase     <= HOLD;
                            busy      <= 1'b1;
                            puf_reset <= 1'b1;
                            puf_in    <= 1'b0;
                        end
                    end
                end
                StApply: begin
                    // LFSR is loaded/stepped on the edge entering this phase
                    puf_sel <= lfsr_state;
                    if (phase == '0) begin
                        state     <= StRace;
                        phase     <= HOLD;
                        puf_reset <= 1'b0;
                        puf_in    <= 1'b1;
                    end else begin
                        phase <= phase - 1'b1;
                    end
                end
                StRace: begin
                    if (phase == '0) begin
                        state <= StSample;
                        phase <= SYNC_HD;
                    end else begin
                        phase <= phase - 1'b1;
                    end
                end
                StSample: begin
                    if (phase == '0) begin
                        ones      <= ones + {{(ONES_W-1){1'b0}}, sync2};
                        vote      <= vote + 1'b1;
                        state     <= StClear;
                        phase     <= HOLD;
                        puf_in    <= 1'b0;
                        puf_reset <= 1'b1;
                    end else begin
                        phase <= phase - 1'b1;
                    end
                end
                StClear: begin
                    if (phase == '0) begin
                        if (vote < NVOTES) begin
                            state     <= StRace;
                            phase     <= HOLD;
                            puf_reset <= 1'b0;
                            puf_in    <= 1'b1;
                        end else begin
                            state         <= StPresent;
                            crp_valid     <= 1'b1;
                            crp_challenge <= puf_sel;
                            crp_ones      <= ones;
                            crp_response  <= (ones > HALF);
                        end
                    end else begin
                        phase <= phase - 1'b1;
                    end
                end
                StPresent: begin
                    if (crp_ready) begin
                        crp_valid <= 1'b0;
                        remaining <= remaining - 16'd1;
                        ones      <= '0;
                        vote      <= '0;
                        if (remaining > 16'd1) begin
                            state <= StApply;
                            phase <= HOLD;
                        end else begin
                            state <= StIdle;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_puf_crp_controller.sv
// Directed bench for puf_crp_controller with a behavioural arbiter-PUF model.
module tb_puf_crp_controller;

    localparam int unsigned N      = 128;
    localparam int unsigned SETTLE = 8;
    localparam int unsigned VOTES  = 5;
    localparam int          LAT    = SETTLE + VOTES * (SETTLE + 2 + SETTLE);

    logic         clk;
    logic         reset;
    logic         start;
    logic [N-1:0] seed;
    logic [15:0]  n_crp;
    logic [N-1:0] puf_sel;
    logic         puf_in;
    logic         puf_reset;
    logic         puf_out;
    logic         crp_valid;
    logic         crp_ready;
    logic [N-1:0] crp_challenge;
    logic         crp_response;
    logic [3:0]   crp_ones;
    logic         busy;
    logic         done;

    int n_checks = 0;
    int n_fail   = 0;

    puf_crp_controller #(
        .N     (N),
        .SETTLE(SETTLE),
        .VOTES (VOTES)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .seed         (seed),
        .n_crp        (n_crp),
        .puf_sel      (puf_sel),
        .puf_in       (puf_in),
        .puf_reset    (puf_reset),
        .puf_out      (puf_out),
        .crp_valid    (crp_valid),
        .crp_ready    (crp_ready),
        .crp_challenge(crp_challenge),
        .crp_response (crp_response),
        .crp_ones     (crp_ones),
        .busy         (busy),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // PUF model: response is parity of sel, optionally flipped per race by the noise mask
    logic        latch = 1'b0;
    int          race_idx = 0;
    int          race_base = 0;
    logic [15:0] noise = '0;
    assign puf_out = latch;

    always @(posedge puf_in or posedge puf_reset) begin
        if (puf_reset) begin
            latch <= 1'b0;
        end else begin
            latch    <= (^puf_sel) ^ noise[4'(race_idx - race_base)];
            race_idx <= race_idx + 1;
        end
    end

    function automatic logic [N-1:0] lfsr_next(input logic [N-1:0] s);
        return {s[N-2:0], s[127] ^ s[125] ^ s[100] ^ s[98]};
    endfunction

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [N-1:0] s, input logic [15:0] n);
        seed  = s;
        n_crp = n;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_valid(output int cycles);
        cycles = 0;
        while (!crp_valid && cycles < 3000) begin
            tick();
            cycles++;
        end
        if (!crp_valid) check("valid_timeout", 128'(crp_valid), 128'(1));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
    endtask

    int           cyc;
    logic [N-1:0] exp_chal;
    logic [N-1:0] saved_chal;
    logic [N-1:0] saved_sel;

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        seed      = '0;
        n_crp     = '0;
        crp_ready = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        // Reset values
        check("rst_puf_sel", puf_sel, '0);
        check("rst_puf_in", 128'(puf_in), 128'(0));
        check("rst_puf_reset", 128'(puf_reset), 128'(1));
        check("rst_valid", 128'(crp_valid), 128'(0));
        check("rst_chal", crp_challenge, '0);
        check("rst_resp", 128'(crp_response), 128'(0));
        check("rst_ones", 128'(crp_ones), 128'(0));
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_done", 128'(done), 128'(0));

        // Single CRP
        crp_ready = 1'b1;
        do_start(128'd1, 16'd1);
        check("single_busy", 128'(busy), 128'(1));
        wait_valid(cyc);
        check("single_latency", 128'(cyc), 128'(LAT));
        check("single_chal", crp_challenge, 128'd1);
        check("single_resp", 128'(crp_response), 128'(1));
        check("single_ones", 128'(crp_ones), 128'(5));
        tick();
        check("single_taken", 128'(crp_valid), 128'(0));
        check("single_done", 128'(done), 128'(1));
        check("single_idle", 128'(busy), 128'(0));
        tick();
        check("single_done_pulse", 128'(done), 128'(0));

        // LFSR sequence from a zero seed
        exp_chal = '1;
        do_start('0, 16'd3);
        for (int k = 0; k < 3; k++) begin
            wait_valid(cyc);
            check($sformatf("seq%0d_chal", k), crp_challenge, exp_chal);
            check($sformatf("seq%0d_resp", k), 128'(crp_response), 128'(^exp_chal));
            check($sformatf("seq%0d_ones", k), 128'(crp_ones), (^exp_chal) ? 128'(5) : 128'(0));
            tick();
            exp_chal = lfsr_next(exp_chal);
        end
        check("seq_done", 128'(done), 128'(1));
        tick();

        // Majority vote with race results 1,0,1,0,0
        race_base = race_idx;
        noise     = 16'b1_1010;
        do_start(128'd1, 16'd1);
        wait_valid(cyc);
        check("vote_ones", 128'(crp_ones), 128'(2));
        check("vote_resp", 128'(crp_response), 128'(0));
        tick();
        noise = '0;
        tick();

        // Backpressure
        crp_ready = 1'b0;
        do_start(128'd1, 16'd2);
        wait_valid(cyc);
        saved_chal = crp_challenge;
        saved_sel  = puf_sel;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("bp_valid", 128'(crp_valid), 128'(1));
            check("bp_chal", crp_challenge, saved_chal);
            check("bp_sel", puf_sel, saved_sel);
        end
        check("bp_chal_val", saved_chal, 128'd1);
        check("bp_puf_reset", 128'(puf_reset), 128'(1));
        crp_ready = 1'b1;
        tick();
        check("bp_taken", 128'(crp_valid), 128'(0));
        check("bp_still_busy", 128'(busy), 128'(1));
        wait_valid(cyc);
        check("bp_second_latency", 128'(cyc), 128'(LAT));
        check("bp_second_chal", crp_challenge, lfsr_next(128'd1));
        check("bp_second_resp", 128'(crp_response), 128'(1));
        tick();
        check("bp_done", 128'(done), 128'(1));
        tick();

        // n_crp == 0
        do_start(128'd7, 16'd0);
        check("zero_done", 128'(done), 128'(1));
        check("zero_busy", 128'(busy), 128'(0));
        tick();
        check("zero_done_pulse", 128'(done), 128'(0));
        check("zero_busy2", 128'(busy), 128'(0));

        // Start while busy is ignored
        do_start(128'd1, 16'd1);
        repeat (5) tick();
        do_start(128'd5, 16'd3);
        wait_valid(cyc);
        check("ign_chal", crp_challenge, 128'd1);
        tick();
        check("ign_done", 128'(done), 128'(1));
        check("ign_busy", 128'(busy), 128'(0));
        tick();

        // Reset mid-RACE
        do_start(128'd1, 16'd1);
        cyc = 0;
        while (!puf_in && cyc < 100) begin
            tick();
            cyc++;
        end
        check("race_reached", 128'(puf_in), 128'(1));
        repeat (3) tick();
        @(posedge clk);
        reset = 1'b1;
        #1;
        check("mid_race_puf_in", 128'(puf_in), 128'(0));
        check("mid_race_puf_reset", 128'(puf_reset), 128'(1));
        check("mid_race_valid", 128'(crp_valid), 128'(0));
        check("mid_race_busy", 128'(busy), 128'(0));
        tick();
        reset = 1'b0;
        tick();

        // Reset while presenting discards the CRP
        crp_ready = 1'b0;
        do_start(128'd1, 16'd1);
        wait_valid(cyc);
        check("pres_valid", 128'(crp_valid), 128'(1));
        #3;
        reset = 1'b1;
        #1;
        check("pres_rst_valid", 128'(crp_valid), 128'(0));
        check("pres_rst_puf_reset", 128'(puf_reset), 128'(1));
        check("pres_rst_busy", 128'(busy), 128'(0));
        do_reset();

        // Clean restart after reset
        crp_ready = 1'b1;
        do_start(128'd1, 16'd1);
        wait_valid(cyc);
        check("restart_latency", 128'(cyc), 128'(LAT));
        check("restart_ones", 128'(crp_ones), 128'(5));
        tick();
        check("restart_done", 128'(done), 128'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
